// File: rtl/isp_uart_frame_rx.sv
// Command-frame receiver behind the UART core: pulls bytes with a CSN/OEN read strobe and
// splits each SOF/LEN/CMD/payload/CHK frame into a cmd strobe, a payload stream and a status pulse.
module isp_uart_frame_rx #(
    parameter int unsigned MAX_LEN        = 64,
    parameter int unsigned HOLDOFF        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  SOF_BYTE       = 8'hA5
) (
    input  logic       CLK,
    input  logic       RESET_N,
    output logic       uart_csn_o,
    output logic       uart_oen_o,
    input  logic [7:0] uart_data_i,
    input  logic       uart_rxrdy_i,
    input  logic       uart_parity_err_i,
    input  logic       uart_framing_err_i,
    input  logic       uart_overflow_i,
    output logic [7:0] cmd_o,
    output logic       cmd_strobe_o,
    output logic [7:0] pl_data_o,
    output logic       pl_valid_o,
    input  logic       pl_ready_i,
    output logic       pl_last_o,
    output logic       frame_done_o,
    output logic [1:0] frame_status_o,
    output logic       busy_o
);

    // Timeout counter is at least 16 bits and widens if TIMEOUT_CYCLES needs more.
    localparam int unsigned     TmoW    = ($clog2(TIMEOUT_CYCLES) > 16) ? $clog2(TIMEOUT_CYCLES) : 16;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      MaxLen  = 8'(MAX_LEN);
    localparam logic [7:0]      Holdoff = 8'(HOLDOFF);

    localparam logic [1:0] StatOk  = 2'b00;
    localparam logic [1:0] StatChk = 2'b01;
    localparam logic [1:0] StatTmo = 2'b10;
    localparam logic [1:0] StatErr = 2'b11;

    typedef enum logic [2:0] {StHunt, StLen, StCmd, StPayload, StChk} state_e;

    state_e          state_q, state_d;
    logic            en_q;
    logic [7:0]      holdoff_q, holdoff_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [7:0]      rem_q, rem_d;
    logic [7:0]      sum_q, sum_d;
    logic [7:0]      cmd_q, cmd_d;
    logic            cmd_strobe_q, cmd_strobe_d;
    logic [7:0]      pl_data_q, pl_data_d;
    logic            pl_valid_q, pl_valid_d;
    logic            pl_last_q, pl_last_d;
    logic            frame_done_q, frame_done_d;
    logic [1:0]      frame_status_q, frame_status_d;

    logic       rd_fire, byte_bad, busy, tmo_run, line_abort, tmo_abort;
    logic [7:0] sum_add;

    // en_q keeps the strobe inactive while reset is asserted and on the first cycle after it.
    assign rd_fire    = en_q && uart_rxrdy_i && (holdoff_q == 8'd0) && (!pl_valid_q || pl_ready_i);
    assign byte_bad   = uart_parity_err_i || uart_framing_err_i;
    assign busy       = (state_q != StHunt);
    assign tmo_run    = busy && !(pl_valid_q && !pl_ready_i);
    assign line_abort = busy && (uart_overflow_i || (rd_fire && byte_bad));
    assign tmo_abort  = tmo_run && (tmo_q == TmoLast);
    assign sum_add    = sum_q + uart_data_i;

    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        sum_d          = sum_q;
        cmd_d          = cmd_q;
        cmd_strobe_d   = 1'b0;
        pl_data_d      = pl_data_q;
        pl_valid_d     = pl_valid_q;
        pl_last_d      = pl_last_q;
        frame_done_d   = 1'b0;
        frame_status_d = frame_status_q;

        if (pl_valid_q && pl_ready_i) begin
            pl_valid_d = 1'b0;
            pl_last_d  = 1'b0;
        end

        // An abort discards any byte captured in the same cycle; a pending payload byte survives.
        if (line_abort || tmo_abort) begin
            state_d        = StHunt;
            frame_done_d   = 1'b1;
            frame_status_d = line_abort ? StatErr : StatTmo;
        end else if (rd_fire && !byte_bad) begin
            unique case (state_q)
                StHunt: begin
                    if (uart_data_i == SOF_BYTE) state_d = StLen;
                end
                StLen: begin
                    if (uart_data_i == 8'd0 || uart_data_i > MaxLen) begin
                        state_d        = StHunt;
                        frame_done_d   = 1'b1;
                        frame_status_d = StatErr;
                    end else begin
                        rem_d   = uart_data_i;
                        sum_d   = uart_data_i;
                        state_d = StCmd;
                    end
                end
                StCmd: begin
                    cmd_d        = uart_data_i;
                    cmd_strobe_d = 1'b1;
                    sum_d        = sum_add;
                    state_d      = StPayload;
                end
                StPayload: begin
                    pl_data_d  = uart_data_i;
                    pl_valid_d = 1'b1;
                    pl_last_d  = (rem_q == 8'd1);
                    sum_d      = sum_add;
                    rem_d      = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = StChk;
                end
                StChk: begin
                    frame_done_d   = 1'b1;
                    frame_status_d = (sum_add == 8'd0) ? StatOk : StatChk;
                    state_d        = StHunt;
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_comb begin
        holdoff_d = holdoff_q;
        if (rd_fire) begin
            holdoff_d = Holdoff;
        end else if (holdoff_q != 8'd0) begin
            holdoff_d = holdoff_q - 8'd1;
        end

        tmo_d = tmo_q;
        if (!busy || rd_fire) begin
            tmo_d = '0;
        end else if (tmo_run) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= StHunt;
            en_q           <= 1'b0;
            holdoff_q      <= 8'd0;
            tmo_q          <= '0;
            rem_q          <= 8'd0;
            sum_q          <= 8'd0;
            cmd_q          <= 8'd0;
            cmd_strobe_q   <= 1'b0;
            pl_data_q      <= 8'd0;
            pl_valid_q     <= 1'b0;
            pl_last_q      <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_status_q <= 2'b00;
        end else begin
            state_q        <= state_d;
            en_q           <= 1'b1;
            holdoff_q      <= holdoff_d;
            tmo_q          <= tmo_d;
            rem_q          <= rem_d;
            sum_q          <= sum_d;
            cmd_q          <= cmd_d;
            cmd_strobe_q   <= cmd_strobe_d;
            pl_data_q      <= pl_data_d;
            pl_valid_q     <= pl_valid_d;
            pl_last_q      <= pl_last_d;
            frame_done_q   <= frame_done_d;
            frame_status_q <= frame_status_d;
        end
    end

    assign uart_csn_o     = !rd_fire;
    assign uart_oen_o     = !rd_fire;
    assign cmd_o          = cmd_q;
    assign cmd_strobe_o   = cmd_strobe_q;
    assign pl_data_o      = pl_data_q;
    assign pl_valid_o     = pl_valid_q;
    assign pl_last_o      = pl_last_q;
    assign frame_done_o   = frame_done_q;
    assign frame_status_o = frame_status_q;
    assign busy_o         = busy;

endmodule

// File: tb/tb_isp_uart_frame_rx.sv
// Scoreboard bench for isp_uart_frame_rx: a queue-backed UART model feeds bytes, expected
// cmd/payload/status events are queued by the stimulus and matched by a negedge monitor.
module tb_isp_uart_frame_rx;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       uart_csn, uart_oen;
    logic [7:0] uart_data;
    logic       uart_rxrdy, uart_parity_err, uart_framing_err, uart_overflow;
    logic [7:0] cmd;
    logic       cmd_strobe;
    logic [7:0] pl_data;
    logic       pl_valid, pl_ready, pl_last;
    logic       frame_done;
    logic [1:0] frame_status;
    logic       busy;

    always #5 CLK = ~CLK;

    isp_uart_frame_rx #(
        .MAX_LEN       (64),
        .HOLDOFF       (3),
        .TIMEOUT_CYCLES(1000),
        .SOF_BYTE      (8'hA5)
    ) dut (
        .CLK               (CLK),
        .RESET_N           (RESET_N),
        .uart_csn_o        (uart_csn),
        .uart_oen_o        (uart_oen),
        .uart_data_i       (uart_data),
        .uart_rxrdy_i      (uart_rxrdy),
        .uart_parity_err_i (uart_parity_err),
        .uart_framing_err_i(uart_framing_err),
        .uart_overflow_i   (uart_overflow),
        .cmd_o             (cmd),
        .cmd_strobe_o      (cmd_strobe),
        .pl_data_o         (pl_data),
        .pl_valid_o        (pl_valid),
        .pl_ready_i        (pl_ready),
        .pl_last_o         (pl_last),
        .frame_done_o      (frame_done),
        .frame_status_o    (frame_status),
        .busy_o            (busy)
    );

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int          strobe_cnt = 0, dbl_cnt = 0, done_cnt = 0;
    int unsigned last_pop_cyc = 0, done_cyc = 0;

    logic [8:0] rxq[$];       // {parity_err, data}
    logic [7:0] exp_cmd[$];
    logic [8:0] exp_pl[$];    // {last, data}
    logic [1:0] exp_done[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got an event, expected none", name);
    endtask

    task automatic push(input logic [7:0] b, input logic perr);
        rxq.push_back({perr, b});
    endtask

    task automatic push_frame1(input logic [7:0] chk);
        push(8'hA5, 1'b0); push(8'h03, 1'b0); push(8'h10, 1'b0);
        push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(chk, 1'b0);
    endtask

    task automatic exp_frame1(input logic [1:0] st);
        exp_cmd.push_back(8'h10);
        exp_pl.push_back({1'b0, 8'h01});
        exp_pl.push_back({1'b0, 8'h02});
        exp_pl.push_back({1'b1, 8'h03});
        exp_done.push_back(st);
    endtask

    task automatic check_reset_vals(input string name);
        check(name, {uart_csn, uart_oen, cmd, cmd_strobe, pl_data, pl_valid, pl_last,
                     frame_done, frame_status, busy}, {2'b11, 23'd0});
    endtask

    // Bounded wait for all queued traffic to complete and the receiver to return to HUNT.
    task automatic drain(input string name);
        int n = 0;
        while ((exp_cmd.size() != 0 || exp_pl.size() != 0 || exp_done.size() != 0 ||
                rxq.size() != 0 || busy) && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        check(name, (n < 5000) ? 32'd1 : 32'd0, 32'd1);
        repeat (20) @(negedge CLK);
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    // UART model: data/rxrdy follow the queue head; the head is popped after a strobe cycle.
    initial begin : uart_model
        logic s, prev_s;
        prev_s           = 1'b0;
        uart_rxrdy       = 1'b0;
        uart_data        = 8'h00;
        uart_parity_err  = 1'b0;
        uart_framing_err = 1'b0;
        uart_overflow    = 1'b0;
        forever begin
            @(negedge CLK);
            s = !uart_csn && !uart_oen;
            if (s) begin
                strobe_cnt++;
                if (prev_s) dbl_cnt++;
            end
            prev_s = s;
            @(posedge CLK);
            #1;
            if (s && rxq.size() != 0) begin
                void'(rxq.pop_front());
                last_pop_cyc = cyc;
            end
            if (!RESET_N) rxq.delete();
            uart_rxrdy = RESET_N && (rxq.size() != 0);
            if (rxq.size() != 0) begin
                {uart_parity_err, uart_data} = rxq[0];
            end else begin
                uart_parity_err = 1'b0;
                uart_data       = 8'h00;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (RESET_N) begin
                if (cmd_strobe) begin
                    if (exp_cmd.size() == 0) unexpected("cmd_strobe");
                    else check("cmd", {24'd0, cmd}, {24'd0, exp_cmd.pop_front()});
                end
                if (pl_valid && pl_ready) begin
                    if (exp_pl.size() == 0) unexpected("payload");
                    else check("payload", {23'd0, pl_last, pl_data}, {23'd0, exp_pl.pop_front()});
                end
                if (frame_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    if (exp_done.size() == 0) unexpected("frame_done");
                    else check("frame_status", {30'd0, frame_status}, {30'd0, exp_done.pop_front()});
                end
            end
        end
    end

    initial begin : stimulus
        int sc, dc, n;
        pl_ready = 1'b1;
        repeat (3) @(negedge CLK);
        check_reset_vals("reset_in");
        @(posedge CLK); #1 RESET_N = 1'b1;
        @(negedge CLK);
        check_reset_vals("reset_out");

        // Good frame.
        exp_frame1(2'b00); push_frame1(8'hE7);
        drain("t1_good");

        // Bad checksum.
        exp_frame1(2'b01); push_frame1(8'h00);
        drain("t2_badchk");

        // Junk before SOF.
        dc = done_cnt;
        push(8'h00, 1'b0); push(8'hFF, 1'b0); push(8'h5A, 1'b0);
        exp_frame1(2'b00); push_frame1(8'hE7);
        drain("t3_junk");
        check("t3_done_count", done_cnt - dc, 1);

        // Downstream stall longer than the timeout on the first payload byte.
        pl_ready = 1'b0;
        exp_frame1(2'b00); push_frame1(8'hE7);
        n = 0;
        while (!pl_valid && n < 200) begin @(negedge CLK); n++; end
        check("t4_pl_valid_seen", (n < 200) ? 32'd1 : 32'd0, 32'd1);
        sc = strobe_cnt;
        dc = done_cnt;
        repeat (1200) @(negedge CLK);
        check("t4_no_strobe", strobe_cnt - sc, 0);
        check("t4_no_done", done_cnt - dc, 0);
        check("t4_busy", {31'd0, busy}, 32'd1);
        @(posedge CLK); #1 pl_ready = 1'b1;
        drain("t4_stall");

        // Inter-byte timeout.
        exp_cmd.push_back(8'h10);
        exp_done.push_back(2'b10);
        push(8'hA5, 1'b0); push(8'h03, 1'b0); push(8'h10, 1'b0);
        drain("t5_timeout");
        check("t5_delay", done_cyc - last_pop_cyc, 1000);

        // Zero length.
        exp_done.push_back(2'b11);
        push(8'hA5, 1'b0); push(8'h00, 1'b0);
        drain("t6a_len0");

        // Parity error on the second payload byte; trailing bytes land in HUNT.
        exp_cmd.push_back(8'h10);
        exp_pl.push_back({1'b0, 8'h01});
        exp_done.push_back(2'b11);
        push(8'hA5, 1'b0); push(8'h03, 1'b0); push(8'h10, 1'b0);
        push(8'h01, 1'b0); push(8'h02, 1'b1); push(8'h03, 1'b0); push(8'hE7, 1'b0);
        drain("t6b_parity");

        // Reset mid-payload.
        exp_cmd.push_back(8'h10);
        exp_pl.push_back({1'b0, 8'h01});
        push(8'hA5, 1'b0); push(8'h03, 1'b0); push(8'h10, 1'b0); push(8'h01, 1'b0);
        n = 0;
        while ((exp_pl.size() != 0 || rxq.size() != 0) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        check("t6c_payload_seen", (n < 500) ? 32'd1 : 32'd0, 32'd1);
        check("t6c_busy_before", {31'd0, busy}, 32'd1);
        dc = done_cnt;
        @(posedge CLK); #1 RESET_N = 1'b0;
        @(negedge CLK);
        check_reset_vals("t6c_in_reset");
        repeat (3) @(posedge CLK);
        #1 RESET_N = 1'b1;
        repeat (50) @(negedge CLK);
        check_reset_vals("t6c_after_reset");
        check("t6c_no_done", done_cnt - dc, 0);

        check("single_cycle_strobe", dbl_cnt, 0);
        check("queues_empty", exp_cmd.size() + exp_pl.size() + exp_done.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
